// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list
//   Checkpointed free list of physical register tags for rename/dispatch.
//   Hands the head tag to dispatch, takes back freed tags from commit, and
//   snapshots/restores the read pointer for branch recovery.
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   dequeue_valid/_phys_reg_tag head tag usable / head tag
//   dequeue_ready               dispatch consumes head this cycle
//   enqueue_valid/_phys_reg_tag freed tag returned this cycle
//   save_checkpoint_*           snapshot head into the round-robin column
//   clear_checkpoint_*          release a column (branch resolved correct)
//   restore_checkpoint_*        roll head back to a column (mispredict)
//   free_count                  number of free tags, 0..FREE_LIST_DEPTH
module phys_reg_free_list #(
  parameter int NUM_PHYS_REGS      = 64,
  parameter int NUM_ARCH_REGS      = 32,
  parameter int FREE_LIST_DEPTH    = NUM_PHYS_REGS - NUM_ARCH_REGS,
  parameter int CHECKPOINT_COLUMNS = 4,
  localparam int TAG_W = $clog2(NUM_PHYS_REGS),
  localparam int IDX_W = $clog2(FREE_LIST_DEPTH),
  localparam int PTR_W = IDX_W + 1,
  localparam int COL_W = $clog2(CHECKPOINT_COLUMNS)
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             dequeue_valid,
  output logic [TAG_W-1:0] dequeue_phys_reg_tag,
  input  logic             dequeue_ready,
  input  logic             enqueue_valid,
  input  logic [TAG_W-1:0] enqueue_phys_reg_tag,
  input  logic             save_checkpoint_valid,
  output logic             save_checkpoint_ready,
  output logic [COL_W-1:0] save_checkpoint_column,
  input  logic             clear_checkpoint_valid,
  input  logic [COL_W-1:0] clear_checkpoint_column,
  input  logic             restore_checkpoint_valid,
  input  logic [COL_W-1:0] restore_checkpoint_column,
  output logic [PTR_W-1:0] free_count
);

  logic [FREE_LIST_DEPTH-1:0][TAG_W-1:0]    r_array;
  logic [PTR_W-1:0]                         r_head, r_tail;
  logic [CHECKPOINT_COLUMNS-1:0][PTR_W-1:0] r_ckpt_head;
  logic [CHECKPOINT_COLUMNS-1:0]            r_ckpt_vld;
  logic [COL_W-1:0]                         r_alloc;

  logic [PTR_W-1:0]              w_count, w_head_adv;
  logic                          w_empty, w_full, w_deq, w_enq, w_save;
  logic [CHECKPOINT_COLUMNS-1:0] w_vld_nxt;
  logic [COL_W-1:0]              w_span, w_dist;

  // Pointers carry one extra wrap bit, so plain subtraction gives 0..DEPTH.
  assign w_count = r_tail - r_head;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == PTR_W'(FREE_LIST_DEPTH));

  // Restore owns the head and the allocation pointer, so it drops both
  // a concurrent dequeue and a concurrent save.
  assign w_deq      = dequeue_ready & ~w_empty & ~restore_checkpoint_valid;
  assign w_enq      = enqueue_valid & ~w_full;
  assign w_save     = save_checkpoint_valid & ~r_ckpt_vld[r_alloc] & ~restore_checkpoint_valid;
  assign w_head_adv = r_head + PTR_W'(w_deq);

  // Column valid update. Priority low->high: clear, restore invalidation,
  // save (save wins over a clear of the same column).
  always_comb begin
    w_vld_nxt = r_ckpt_vld;
    w_span    = r_alloc - restore_checkpoint_column;
    w_dist    = '0;
    if (clear_checkpoint_valid) w_vld_nxt[clear_checkpoint_column] = 1'b0;
    if (restore_checkpoint_valid) begin
      for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
        // Younger columns sit between the restored one and alloc-1. A zero
        // span means every column was live (alloc wrapped onto it).
        w_dist = COL_W'(i) - restore_checkpoint_column;
        if ((w_span == '0) || (w_dist < w_span)) w_vld_nxt[i] = 1'b0;
      end
    end
    if (w_save) w_vld_nxt[r_alloc] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < FREE_LIST_DEPTH; i++)
        r_array[i] <= TAG_W'(NUM_ARCH_REGS + i);
      r_head      <= '0;
      r_tail      <= PTR_W'(FREE_LIST_DEPTH);
      r_ckpt_head <= '0;
      r_ckpt_vld  <= '0;
      r_alloc     <= '0;
    end else begin
      if (w_enq) begin
        r_array[r_tail[IDX_W-1:0]] <= enqueue_phys_reg_tag;
        r_tail                     <= r_tail + 1'b1;
      end
      if (restore_checkpoint_valid) begin
        r_head  <= r_ckpt_head[restore_checkpoint_column];
        r_alloc <= restore_checkpoint_column;
      end else begin
        r_head <= w_head_adv;
        if (w_save) begin
          // Snapshot reflects this cycle's dequeue so the branch's own
          // destination reg stays allocated after recovery.
          r_ckpt_head[r_alloc] <= w_head_adv;
          r_alloc              <= r_alloc + 1'b1;
        end
      end
      r_ckpt_vld <= w_vld_nxt;
    end
  end

  assign dequeue_valid          = ~w_empty;
  assign dequeue_phys_reg_tag   = r_array[r_head[IDX_W-1:0]];
  assign save_checkpoint_ready  = ~r_ckpt_vld[r_alloc];
  assign save_checkpoint_column = r_alloc;
  assign free_count             = w_count;

endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       dequeue_valid;
  logic [5:0] dequeue_phys_reg_tag;
  logic       dequeue_ready = 1'b0;
  logic       enqueue_valid = 1'b0;
  logic [5:0] enqueue_phys_reg_tag = '0;
  logic       save_checkpoint_valid = 1'b0;
  logic       save_checkpoint_ready;
  logic [1:0] save_checkpoint_column;
  logic       clear_checkpoint_valid = 1'b0;
  logic [1:0] clear_checkpoint_column = '0;
  logic       restore_checkpoint_valid = 1'b0;
  logic [1:0] restore_checkpoint_column = '0;
  logic [5:0] free_count;

  int n_assert = 0;
  int n_fail   = 0;

  phys_reg_free_list dut (
    .CLK                       (CLK),
    .RST                       (RST),
    .dequeue_valid             (dequeue_valid),
    .dequeue_phys_reg_tag      (dequeue_phys_reg_tag),
    .dequeue_ready             (dequeue_ready),
    .enqueue_valid             (enqueue_valid),
    .enqueue_phys_reg_tag      (enqueue_phys_reg_tag),
    .save_checkpoint_valid     (save_checkpoint_valid),
    .save_checkpoint_ready     (save_checkpoint_ready),
    .save_checkpoint_column    (save_checkpoint_column),
    .clear_checkpoint_valid    (clear_checkpoint_valid),
    .clear_checkpoint_column   (clear_checkpoint_column),
    .restore_checkpoint_valid  (restore_checkpoint_valid),
    .restore_checkpoint_column (restore_checkpoint_column),
    .free_count                (free_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One edge; inputs are sampled there, outputs checked 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
    dequeue_ready            = 1'b0;
    enqueue_valid            = 1'b0;
    save_checkpoint_valid    = 1'b0;
    clear_checkpoint_valid   = 1'b0;
    restore_checkpoint_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic deq_n(input int n);
    repeat (n) begin
      dequeue_ready = 1'b1;
      tick();
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " count"}, free_count, 32);
    chk({tag, " dvalid"}, dequeue_valid, 1);
    chk({tag, " tag"}, dequeue_phys_reg_tag, 32);
    chk({tag, " sready"}, save_checkpoint_ready, 1);
    chk({tag, " scol"}, save_checkpoint_column, 0);
  endtask

  initial begin
    logic [5:0] q[$];
    logic d, e;
    logic [5:0] t;

    // Reset state
    do_reset();
    chk_reset_state("reset");

    // 32 back-to-back dequeues drain tags 32..63
    for (int i = 0; i < 32; i++) begin
      chk("drain tag", dequeue_phys_reg_tag, 32 + i);
      chk("drain count", free_count, 32 - i);
      dequeue_ready = 1'b1;
      tick();
    end
    chk("empty count", free_count, 0);
    chk("empty dvalid", dequeue_valid, 0);

    // Enqueue into empty list, visible next cycle
    enqueue_valid = 1'b1; enqueue_phys_reg_tag = 6'd5;
    tick();
    chk("enq5 dvalid", dequeue_valid, 1);
    chk("enq5 tag", dequeue_phys_reg_tag, 5);
    chk("enq5 count", free_count, 1);
    dequeue_ready = 1'b1;
    tick();
    chk("deq5 count", free_count, 0);
    chk("deq5 dvalid", dequeue_valid, 0);

    // Dequeue + enqueue while empty: no bypass, dequeue ignored
    dequeue_ready = 1'b1; enqueue_valid = 1'b1; enqueue_phys_reg_tag = 6'd9;
    tick();
    chk("nobypass count", free_count, 1);
    chk("nobypass tag", dequeue_phys_reg_tag, 9);

    // Checkpoint restore
    do_reset();
    deq_n(3);
    save_checkpoint_valid = 1'b1;
    tick();
    chk("save0 nextcol", save_checkpoint_column, 1);
    deq_n(4);
    chk("pre-restore tag", dequeue_phys_reg_tag, 39);
    chk("pre-restore count", free_count, 25);
    restore_checkpoint_valid = 1'b1; restore_checkpoint_column = 2'd0;
    tick();
    chk("restore tag", dequeue_phys_reg_tag, 35);
    chk("restore count", free_count, 29);
    chk("restore scol", save_checkpoint_column, 0);
    chk("restore sready", save_checkpoint_ready, 1);

    // Save in the same cycle as a dequeue snapshots the post-dequeue head
    dequeue_ready = 1'b1; save_checkpoint_valid = 1'b1;
    tick();
    deq_n(2);
    chk("savedeq pre tag", dequeue_phys_reg_tag, 38);
    restore_checkpoint_valid = 1'b1; restore_checkpoint_column = 2'd0;
    tick();
    chk("savedeq restore tag", dequeue_phys_reg_tag, 36);
    chk("savedeq restore count", free_count, 28);

    // Save + clear of the same column: save wins
    do_reset();
    save_checkpoint_valid = 1'b1; clear_checkpoint_valid = 1'b1; clear_checkpoint_column = 2'd0;
    tick();
    chk("saveclr col", save_checkpoint_column, 1);
    repeat (3) begin
      save_checkpoint_valid = 1'b1;
      tick();
    end
    chk("saveclr wrapcol", save_checkpoint_column, 0);
    chk("saveclr ready", save_checkpoint_ready, 0);

    // Column exhaustion, clear, restore of an older column
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("exh col", save_checkpoint_column, i);
      chk("exh ready", save_checkpoint_ready, 1);
      save_checkpoint_valid = 1'b1;
      tick();
    end
    chk("full ready", save_checkpoint_ready, 0);
    chk("full col", save_checkpoint_column, 0);
    clear_checkpoint_valid = 1'b1; clear_checkpoint_column = 2'd0;
    tick();
    chk("clr0 ready", save_checkpoint_ready, 1);
    chk("clr0 col", save_checkpoint_column, 0);
    restore_checkpoint_valid = 1'b1; restore_checkpoint_column = 2'd1;
    tick();
    chk("rst1 col", save_checkpoint_column, 1);
    chk("rst1 ready", save_checkpoint_ready, 1);
    chk("rst1 count", free_count, 32);
    save_checkpoint_valid = 1'b1; tick();
    chk("rst1 col2 ready", save_checkpoint_ready, 1);
    chk("rst1 col2", save_checkpoint_column, 2);
    save_checkpoint_valid = 1'b1; tick();
    chk("rst1 col3 ready", save_checkpoint_ready, 1);
    save_checkpoint_valid = 1'b1; tick();
    chk("rst1 col0 ready", save_checkpoint_ready, 1);
    chk("rst1 col0", save_checkpoint_column, 0);
    save_checkpoint_valid = 1'b1; tick();
    chk("rst1 col1 busy", save_checkpoint_ready, 0);

    // Restore + dequeue + enqueue + save in one cycle
    do_reset();
    deq_n(30);
    chk("sim pre tag", dequeue_phys_reg_tag, 62);
    chk("sim pre count", free_count, 2);
    save_checkpoint_valid = 1'b1; tick();
    deq_n(1);
    chk("sim pre2 tag", dequeue_phys_reg_tag, 63);
    restore_checkpoint_valid = 1'b1; restore_checkpoint_column = 2'd0;
    dequeue_ready = 1'b1; enqueue_valid = 1'b1; enqueue_phys_reg_tag = 6'd7;
    save_checkpoint_valid = 1'b1;
    tick();
    chk("sim tag", dequeue_phys_reg_tag, 62);
    chk("sim count", free_count, 3);
    chk("sim scol", save_checkpoint_column, 0);
    chk("sim sready", save_checkpoint_ready, 1);
    deq_n(1);
    chk("sim tag2", dequeue_phys_reg_tag, 63);
    deq_n(1);
    chk("sim tag3", dequeue_phys_reg_tag, 7);
    chk("sim count3", free_count, 1);
    deq_n(1);
    chk("sim drained", dequeue_valid, 0);

    // Dequeue + enqueue at count 10
    do_reset();
    deq_n(22);
    chk("c10 count", free_count, 10);
    chk("c10 tag", dequeue_phys_reg_tag, 54);
    dequeue_ready = 1'b1; enqueue_valid = 1'b1; enqueue_phys_reg_tag = 6'd3;
    tick();
    chk("c10 both count", free_count, 10);
    chk("c10 both tag", dequeue_phys_reg_tag, 55);

    // Reset mid-operation overrides all other inputs
    RST = 1'b1; dequeue_ready = 1'b1; enqueue_valid = 1'b1;
    save_checkpoint_valid = 1'b1; restore_checkpoint_valid = 1'b1;
    restore_checkpoint_column = 2'd2;
    tick();
    RST = 1'b0;
    chk_reset_state("midrst");

    // Random dequeue/enqueue across pointer wrap against a reference FIFO
    do_reset();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(6'(32 + i));
    for (int i = 0; i < 100; i++) begin
      chk("rnd count", free_count, q.size());
      chk("rnd bound", (free_count <= 6'd32), 1);
      if (q.size() > 0) chk("rnd tag", dequeue_phys_reg_tag, q[0]);
      d = (q.size() > 0) && ($urandom_range(0, 3) != 0);
      e = (q.size() < 32) && ($urandom_range(0, 3) != 0);
      t = 6'($urandom_range(0, 63));
      dequeue_ready = d; enqueue_valid = e; enqueue_phys_reg_tag = t;
      tick();
      if (d) void'(q.pop_front());
      if (e) q.push_back(t);
    end
    chk("rnd final count", free_count, q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
